cordic_vm_seq: RTL

- Sequential, handshaked CORDIC vectoring engine. Computes phase, and optionally magnitude, of a complex sample (i_u_real, i_u_imag).
- Performs one micro-rotation per clock over ITER cycles, so a single adder set is shared across iterations.
- Successor to the combinational vectoring block: widened internal datapath (no overflow at -1.0 inputs), magnitude output, optional 1/K gain compensation, valid/ready flow control.
- Sits between the complex-sample producer and phase/magnitude consumers in the receiver datapath.

---
 rtl/cordic_vm_seq.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/cordic_vm_seq.sv
// Sequential CORDIC vectoring engine: one micro-rotation per clock, phase and
// magnitude of a complex sample with valid/ready handshaking on both sides.
module cordic_vm_seq #(
    parameter int unsigned U_WL      = 9,
    parameter int unsigned U_F       = 8,
    parameter int unsigned P_WL      = 11,
    parameter int unsigned P_F       = 7,
    parameter int unsigned ITER      = 5,
    parameter int unsigned GAIN_COMP = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic signed [U_WL-1:0]   i_u_real,
    input  logic signed [U_WL-1:0]   i_u_imag,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic signed [P_WL-1:0]   o_phase,
    output logic signed [U_WL+1:0]   o_mag
);

    localparam int unsigned XW  = U_WL + 2;
    localparam int unsigned KW  = 4;
    localparam int unsigned ASH = 15 - P_F;

    localparam logic [KW-1:0]        KLAST = KW'(ITER - 1);
    localparam logic signed [P_WL-1:0] PI2 = P_WL'(51472 >> ASH);

    if (P_F < 1 || P_F > 15) begin : g_bad_pf
        $error("cordic_vm_seq: P_F must be in 1..15");
    end
    if (ITER < 1 || ITER > 11) begin : g_bad_iter
        $error("cordic_vm_seq: ITER must be in 1..11");
    end
    if (U_F >= U_WL) begin : g_bad_uf
        $error("cordic_vm_seq: U_F must be smaller than U_WL");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        COMP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state;
    logic [KW-1:0]          k;
    logic signed [XW-1:0]   x;
    logic signed [XW-1:0]   y;
    logic signed [P_WL-1:0] z;

    logic signed [XW-1:0]   re_x;
    logic signed [XW-1:0]   im_x;
    logic signed [XW-1:0]   pre_x;
    logic signed [XW-1:0]   pre_y;
    logic signed [P_WL-1:0] pre_z;
    logic signed [XW-1:0]   x_sh;
    logic signed [XW-1:0]   y_sh;
    logic signed [P_WL-1:0] a_k;
    logic signed [XW-1:0]   x_rot;
    logic signed [XW-1:0]   y_rot;
    logic signed [P_WL-1:0] z_rot;
    logic signed [XW-1:0]   x_comp;

    // arctan(2^-k) in Q.15, truncated to P_F fractional bits
    function automatic logic signed [P_WL-1:0] atan_lut(input logic [KW-1:0] idx);
        case (idx)
            4'd0:    return P_WL'(25736 >> ASH);
            4'd1:    return P_WL'(15193 >> ASH);
            4'd2:    return P_WL'(8027 >> ASH);
            4'd3:    return P_WL'(4075 >> ASH);
            4'd4:    return P_WL'(2045 >> ASH);
            4'd5:    return P_WL'(1024 >> ASH);
            4'd6:    return P_WL'(512 >> ASH);
            4'd7:    return P_WL'(256 >> ASH);
            4'd8:    return P_WL'(128 >> ASH);
            4'd9:    return P_WL'(64 >> ASH);
            4'd10:   return P_WL'(32 >> ASH);
            default: return '0;
        endcase
    endfunction

    // Sign-extend before negating so that -(-2^(U_WL-1)) is representable
    assign re_x = XW'(i_u_real);
    assign im_x = XW'(i_u_imag);

    // Quadrant pre-rotation into the right half plane
    always_comb begin
        pre_x = re_x;
        pre_y = im_x;
        pre_z = '0;
        if (re_x[XW-1]) begin
            if (!im_x[XW-1]) begin
                pre_x = im_x;
                pre_y = -re_x;
                pre_z = PI2;
            end else begin
                pre_x = -im_x;
                pre_y = re_x;
                pre_z = -PI2;
            end
        end
    end

    // Shared micro-rotation datapath; y==0 steers as non-negative
    always_comb begin
        x_sh  = x >>> k;
        y_sh  = y >>> k;
        a_k   = atan_lut(k);
        x_rot = x + y_sh;
        y_rot = y - x_sh;
        z_rot = z + a_k;
        if (y[XW-1]) begin
            x_rot = x - y_sh;
            y_rot = y + x_sh;
            z_rot = z - a_k;
        end
    end

    // 1/K ~= 1/2 + 1/8 - 1/64 - 1/512, each term truncated
    always_comb begin
        x_comp = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            k       <= '0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_phase <= '0;
            o_mag   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        x       <= pre_x;
                        y       <= pre_y;
                        z       <= pre_z;
                        k       <= '0;
                        o_ready <= 1'b0;
                        state   <= ROT;
                    end
                end
                ROT: begin
                    x <= x_rot;
                    y <= y_rot;
                    z <= z_rot;
                    k <= k + KW'(1);
                    if (k == KLAST) begin
                        if (GAIN_COMP != 0) begin
                            state <= COMP;
                        end else begin
                            o_phase <= z_rot;
                            o_mag   <= x_rot;
                            o_valid <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                COMP: begin
                    x       <= x_comp;
                    o_phase <= z;
                    o_mag   <= x_comp;
                    o_valid <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
